axi_lite_master: RTL

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

---
 rtl/axi_lite_pkg.sv | 26 ++
 rtl/axi_lite_master.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite master: FSM state encoding, latched command
// record and the default watchdog period.
package axi_lite_pkg;

    localparam int unsigned DEFAULT_TIMEOUT = 256;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StDone
    } state_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    function automatic logic is_busy(state_e s);
        return s inside {StWrReq, StWrResp, StRdReq, StRdResp};
    endfunction

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite master with one outstanding transfer, bridging a cmd/rsp handshake to AW/W/B and AR/R.
// Define AXIL_MASTER_TIMEOUT_EN to enable the inline watchdog that abandons unanswered transfers.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,

    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic        m_bvalid,
    output logic        m_bready,

    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic        m_rvalid,
    output logic        m_rready
);

    state_e      state_q, state_d;
    cmd_t        cmd_q, cmd_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        timeout;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    cmd_d.write = cmd_write;
                    cmd_d.addr  = cmd_addr;
                    cmd_d.wdata = cmd_wdata;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    rdata_d     = '0;
                    state_d     = cmd_write ? StWrReq : StRdReq;
                end
            end
            StWrReq: begin
                // AW and W complete independently; move on once both have been taken.
                aw_done_d = aw_done_q | m_awready;
                w_done_d  = w_done_q | m_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = StWrResp;
                end
            end
            StWrResp: begin
                if (m_bvalid) begin
                    rdata_d = '0;
                    state_d = StDone;
                end
            end
            StRdReq: begin
                if (m_arready) begin
                    state_d = StRdResp;
                end
            end
            StRdResp: begin
                if (m_rvalid) begin
                    rdata_d = m_rdata;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (timeout) begin
            rdata_d = '0;
            state_d = StDone;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cmd_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    logic [31:0] timer_q, timer_d;
    logic        err_q, err_d;

    // Counts busy cycles; fires on the last allowed one so the FSM leaves after exactly
    // TIMEOUT_CYCLES cycles of waiting.
    assign timeout = is_busy(state_q) && (timer_q == TIMEOUT_CYCLES - 1);

    always_comb begin
        timer_d = timer_q;
        err_d   = err_q;
        if (state_q == StIdle) begin
            timer_d = '0;
            err_d   = 1'b0;
        end else if (is_busy(state_q)) begin
            timer_d = timer_q + 32'd1;
        end
        if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
    assign rsp_err            = 1'b0;
`endif

    assign cmd_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StDone);
    assign rsp_rdata = rdata_q;

    assign m_awaddr  = cmd_q.addr;
    assign m_wdata   = cmd_q.wdata;
    assign m_araddr  = cmd_q.addr;
    assign m_awvalid = (state_q == StWrReq) && !aw_done_q;
    assign m_wvalid  = (state_q == StWrReq) && !w_done_q;
    assign m_bready  = (state_q == StWrResp);
    assign m_arvalid = (state_q == StRdReq);
    assign m_rready  = (state_q == StRdResp);

endmodule
